// File: rtl/trail_writer_pkg.sv
// trail_writer_pkg
// Shared definitions for the light-cycle trail writer: arena geometry,
// framebuffer cell encoding, bit positions of the fields inside a bike
// position word, and the controller state encoding.
// Ports: none (package).

package trail_writer_pkg;

  localparam int ARENA_COLS = 160;
  localparam int ARENA_ROWS = 120;
  localparam int NUM_BIKES  = 4;

  localparam int ADDR_W    = 15;
  localparam int POS_X_LSB = 0;
  localparam int POS_X_W   = 8;
  localparam int POS_Y_LSB = 8;
  localparam int POS_Y_W   = 7;
  localparam int POS_W     = POS_X_W + POS_Y_W;

  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_BIKE1 = 3'd1;
  localparam logic [2:0] CELL_BIKE2 = 3'd2;
  localparam logic [2:0] CELL_BIKE3 = 3'd3;
  localparam logic [2:0] CELL_BIKE4 = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;

  // A bike's trail cell holds its one-based id so that zero stays "empty".
  function automatic logic [2:0] bikeCell(input logic [1:0] idx);
    return {1'b0, idx} + CELL_BIKE1;
  endfunction

endpackage

// File: rtl/trail_writer_cell_addr.sv
// cell_addr
// Combinational conversion of an (x, y) cell coordinate into a linear
// framebuffer address y*COLS + x, kept at 15 bits throughout so that no
// in-range coordinate is ever truncated.
// Ports:
//   x    - column, 8 bits
//   y    - row, 7 bits
//   addr - linear cell address, 15 bits

module cell_addr
  import trail_writer_pkg::*;
#(
  parameter int COLS = ARENA_COLS
) (
  input  logic [POS_X_W-1:0] x,
  input  logic [POS_Y_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] xWide;
  logic [ADDR_W-1:0] yWide;

  assign xWide = ADDR_W'(x);
  assign yWide = ADDR_W'(y);

  // The default 160-column arena factors as 128 + 32, so the multiply
  // collapses to two shifts and an add; other widths fall back to a
  // plain multiply.
  generate
    if (COLS == 160) begin : gShiftAdd
      assign addr = (yWide << 7) + (yWide << 5) + xWide;
    end else begin : gMultiply
      assign addr = (yWide * ADDR_W'(COLS)) + xWide;
    end
  endgenerate

endmodule

// File: rtl/trail_writer.sv
// trail_writer
// Watches four bike position words and, whenever a bike enters a new cell,
// reads that cell from the framebuffer: an occupied (or off-arena) cell
// marks the bike as crashed, an empty one is stamped with the bike id.
// A clear request sweeps the whole arena back to empty.
// Ports:
//   clock, reset      - clock and asynchronous active-low reset
//   bikeone..bikefour - position words: [7:0] x, [14:8] y
//   masterSwitch      - game running; low stops new trail updates
//   clear_req         - one-cycle request to wipe the arena
//   fb_addr, fb_re, fb_we, fb_wdata, fb_rdata - framebuffer port
//   crash             - sticky crash flag per bike (bit0 = bikeone)
//   busy              - controller is not idle

module trail_writer
  import trail_writer_pkg::*;
#(
  parameter int COLS = ARENA_COLS,
  parameter int ROWS = ARENA_ROWS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       bikeone,
  input  logic [31:0]       biketwo,
  input  logic [31:0]       bikethree,
  input  logic [31:0]       bikefour,
  input  logic              masterSwitch,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_re,
  output logic              fb_we,
  output logic [2:0]        fb_wdata,
  input  logic [2:0]        fb_rdata,
  output logic [3:0]        crash,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  logic [NUM_BIKES-1:0][POS_W-1:0] posQ;
  logic [NUM_BIKES-1:0][POS_W-1:0] lastPos;
  logic [NUM_BIKES-1:0]            lastValid;
  logic [NUM_BIKES-1:0]            pending;
  logic [2:0]                      state;
  logic [1:0]                      curIdx;
  logic [1:0]                      pickIdx;
  logic                            anyPending;
  logic [POS_W-1:0]                curPos;
  logic [POS_X_W-1:0]              curX;
  logic [POS_Y_W-1:0]              curY;
  logic [ADDR_W-1:0]               cellAddr;
  logic [ADDR_W-1:0]               clearAddr;
  logic                            inRange;
  logic                            wrActive;
  logic                            unusedPosBits;

  assign unusedPosBits = ^{bikeone[31:POS_W], biketwo[31:POS_W],
                           bikethree[31:POS_W], bikefour[31:POS_W]};

  assign curX = curPos[POS_X_LSB +: POS_X_W];
  assign curY = curPos[POS_Y_LSB +: POS_Y_W];

  cell_addr #(.COLS(COLS)) uCellAddr (
    .x    (curX),
    .y    (curY),
    .addr (cellAddr)
  );

  // A bike needs service when the game runs, it has not crashed, and its
  // registered position differs from the last cell it stamped (or it has
  // never stamped one since the last clear).
  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_BIKES; i++) begin
      pending[i] = masterSwitch && !crash[i] &&
                   (!lastValid[i] || (posQ[i] != lastPos[i]));
    end
  end

  // Pick the lowest-numbered pending bike; scanning downward lets the
  // lowest index overwrite any higher one found earlier.
  always_comb begin
    pickIdx    = '0;
    anyPending = 1'b0;
    for (int i = NUM_BIKES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pickIdx    = 2'(i);
        anyPending = 1'b1;
      end
    end
  end

  assign inRange  = (int'(curX) < COLS) && (int'(curY) < ROWS);
  assign wrActive = (state == ST_WR) && !clear_req;
  assign busy     = (state != ST_IDLE);

  // Framebuffer strobes come straight from the state so that the read
  // data lands exactly in CHK. A clear request seen during WR suppresses
  // the write, since the arena is about to be wiped anyway.
  always_comb begin
    fb_re    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = CELL_EMPTY;
    if ((state == ST_RD) && inRange) begin
      fb_re   = 1'b1;
      fb_addr = cellAddr;
    end else if (wrActive) begin
      fb_we    = 1'b1;
      fb_addr  = cellAddr;
      fb_wdata = bikeCell(curIdx);
    end else if (state == ST_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clearAddr;
    end
  end

  // Controller and bookkeeping registers. A clear request takes priority
  // from every state, restarts the sweep at address 0, and forgets all
  // crash flags and stamped positions on the way in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      crash     <= '0;
      posQ      <= '0;
      lastPos   <= '0;
      lastValid <= '0;
      curIdx    <= '0;
      curPos    <= '0;
      clearAddr <= '0;
    end else begin
      posQ[0] <= bikeone[POS_W-1:0];
      posQ[1] <= biketwo[POS_W-1:0];
      posQ[2] <= bikethree[POS_W-1:0];
      posQ[3] <= bikefour[POS_W-1:0];
      if (clear_req) begin
        state     <= ST_CLEAR;
        clearAddr <= '0;
        crash     <= '0;
        lastValid <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (anyPending) begin
              curIdx <= pickIdx;
              curPos <= posQ[pickIdx];
              state  <= ST_RD;
            end
          end
          ST_CLEAR: begin
            if (clearAddr == LAST_CELL) begin
              state <= ST_IDLE;
            end else begin
              clearAddr <= clearAddr + 1'b1;
            end
          end
          ST_RD: begin
            if (!inRange) begin
              crash[curIdx] <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (fb_rdata != CELL_EMPTY) begin
              crash[curIdx] <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              state <= ST_WR;
            end
          end
          ST_WR: begin
            lastPos[curIdx]   <= curPos;
            lastValid[curIdx] <= 1'b1;
            state             <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer
// Scoreboard bench for trail_writer: stimulus pushes the expected
// framebuffer accesses (kind, address, data, cycle) into a queue and a
// forked monitor pops one entry for every strobe the design raises.
// A behavioural framebuffer returns read data one cycle after fb_re.

module tb_trail_writer;

  typedef struct {
    bit isWrite;
    int addr;
    int data;
    int cycle;
  } txn_t;

  logic        clock;
  logic        reset;
  logic [31:0] bikeWord [4];
  logic        masterSwitch;
  logic        clear_req;
  logic [14:0] fb_addr;
  logic        fb_re;
  logic        fb_we;
  logic [2:0]  fb_wdata;
  logic [2:0]  fbRdata;
  logic [3:0]  crash;
  logic        busy;

  logic [2:0]  mem [0:32767];
  txn_t        expQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  trail_writer dut (
    .clock        (clock),
    .reset        (reset),
    .bikeone      (bikeWord[0]),
    .biketwo      (bikeWord[1]),
    .bikethree    (bikeWord[2]),
    .bikefour     (bikeWord[3]),
    .masterSwitch (masterSwitch),
    .clear_req    (clear_req),
    .fb_addr      (fb_addr),
    .fb_re        (fb_re),
    .fb_we        (fb_we),
    .fb_wdata     (fb_wdata),
    .fb_rdata     (fbRdata),
    .crash        (crash),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle stamp used to check the latency of every access.
  always @(posedge clock) cyc <= cyc + 1;

  // Framebuffer model: synchronous write, read data one cycle after fb_re.
  always @(posedge clock) begin
    if (fb_we) mem[fb_addr] <= fb_wdata;
    fbRdata <= fb_re ? mem[fb_addr] : 3'd0;
  end

  function automatic int cellOf(input int x, input int y);
    return y * 160 + x;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Junk in the unused upper bits must never influence the design.
  task automatic applyStimulus(input int bike, input int x, input int y);
    logic [16:0] junk;
    junk = 17'($urandom);
    bikeWord[bike] = {junk, 7'(y), 8'(x)};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectRead(input int addr, input int cycle);
    txn_t t;
    t.isWrite = 1'b0;
    t.addr    = addr;
    t.data    = 0;
    t.cycle   = cycle;
    expQ.push_back(t);
  endtask

  task automatic expectWrite(input int addr, input int data, input int cycle);
    txn_t t;
    t.isWrite = 1'b1;
    t.addr    = addr;
    t.data    = data;
    t.cycle   = cycle;
    expQ.push_back(t);
  endtask

  // An empty target cell costs a read in RD and a write two cycles later.
  task automatic expectPlacement(input int bike, input int x, input int y, input int rdCycle);
    expectRead(cellOf(x, y), rdCycle);
    expectWrite(cellOf(x, y), bike + 1, rdCycle + 2);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetCrash", 32'(crash), 0);
    checkOutput("resetStrobes", {30'd0, fb_re, fb_we}, 0);
    checkOutput("resetAddr", 32'(fb_addr), 0);
    checkOutput("resetWdata", 32'(fb_wdata), 0);
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic monitorLoop();
    txn_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        checks++;
        if (fb_re && fb_we) begin
          fails++;
          $display("[TB] FAIL strobeOverlap: re=1 we=1 at cycle %0d, required at most one", cyc);
        end else if (fb_re || fb_we) begin
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpectedAccess: re=%0b we=%0b addr=%0d data=%0d at cycle %0d, required none",
                     fb_re, fb_we, fb_addr, fb_wdata, cyc);
          end else begin
            e = expQ.pop_front();
            if ((e.isWrite != fb_we) || (e.addr != int'(fb_addr)) || (e.cycle != cyc) ||
                (e.isWrite && (e.data != int'(fb_wdata)))) begin
              fails++;
              $display("[TB] FAIL access: got we=%0b addr=%0d data=%0d cycle=%0d, expected we=%0b addr=%0d data=%0d cycle=%0d",
                       fb_we, fb_addr, fb_wdata, cyc, e.isWrite, e.addr, e.data, e.cycle);
            end
          end
        end else if (fb_addr != 15'd0) begin
          fails++;
          $display("[TB] FAIL idleAddr: got %0d at cycle %0d, expected 0", fb_addr, cyc);
        end
      end
    end
  endtask

  initial begin
    int c;
    int d;
    reset        = 1'b1;
    masterSwitch = 1'b0;
    clear_req    = 1'b0;
    for (int i = 0; i < 4; i++) bikeWord[i] = 32'd0;
    fork
      monitorLoop();
    join_none
    #1;
    @(posedge clock);
    #1;
    doReset();

    $display("[TB] full arena clear after reset");
    c = cyc;
    clear_req = 1'b1;
    for (int j = 0; j < 19200; j++) expectWrite(j, 0, c + 1 + j);
    step(1);
    clear_req = 1'b0;
    stepTo(c + 19200);
    checkOutput("clearBusyLast", 32'(busy), 1);
    step(1);
    checkOutput("clearBusyFall", 32'(busy), 0);
    checkOutput("clearDrained", expQ.size(), 0);

    $display("[TB] initial placement and single move");
    applyStimulus(0, 10, 5);
    applyStimulus(1, 50, 40);
    applyStimulus(2, 100, 60);
    applyStimulus(3, 150, 100);
    step(4);
    checkOutput("switchOffIdle", 32'(busy), 0);
    c = cyc;
    masterSwitch = 1'b1;
    expectPlacement(0, 10, 5, c + 1);
    expectPlacement(1, 50, 40, c + 5);
    expectPlacement(2, 100, 60, c + 9);
    expectPlacement(3, 150, 100, c + 13);
    step(16);
    checkOutput("placeDrained", expQ.size(), 0);
    checkOutput("placeCrash", 32'(crash), 0);
    c = cyc;
    applyStimulus(0, 11, 5);
    expectPlacement(0, 11, 5, c + 2);
    step(5);
    checkOutput("moveDrained", expQ.size(), 0);
    checkOutput("moveCrash", 32'(crash), 0);
    applyStimulus(0, 11, 5);
    step(6);
    checkOutput("junkBitsIdle", 32'(busy), 0);

    $display("[TB] bike two runs into a trail");
    c = cyc;
    applyStimulus(1, 11, 5);
    expectRead(811, c + 2);
    step(5);
    checkOutput("hitDrained", expQ.size(), 0);
    checkOutput("hitCrash", 32'(crash), 32'b0010);
    applyStimulus(1, 60, 40);
    step(8);
    checkOutput("crashSticky", 32'(crash), 32'b0010);

    $display("[TB] two bikes into the same cell");
    masterSwitch = 1'b0;
    applyStimulus(0, 20, 19);
    applyStimulus(1, 70, 70);
    applyStimulus(2, 21, 20);
    applyStimulus(3, 150, 110);
    doReset();
    step(2);
    c = cyc;
    masterSwitch = 1'b1;
    expectPlacement(0, 20, 19, c + 1);
    expectPlacement(1, 70, 70, c + 5);
    expectPlacement(2, 21, 20, c + 9);
    expectPlacement(3, 150, 110, c + 13);
    step(16);
    c = cyc;
    applyStimulus(0, 20, 20);
    applyStimulus(2, 20, 20);
    expectRead(3220, c + 2);
    expectWrite(3220, 1, c + 4);
    expectRead(3220, c + 6);
    step(8);
    checkOutput("tieDrained", expQ.size(), 0);
    checkOutput("tieCrash", 32'(crash), 32'b0100);

    $display("[TB] off-arena bike and corner cell");
    masterSwitch = 1'b0;
    applyStimulus(0, 5, 100);
    applyStimulus(1, 6, 100);
    applyStimulus(2, 159, 119);
    applyStimulus(3, 160, 10);
    doReset();
    step(2);
    c = cyc;
    masterSwitch = 1'b1;
    expectPlacement(0, 5, 100, c + 1);
    expectPlacement(1, 6, 100, c + 5);
    expectPlacement(2, 159, 119, c + 9);
    step(14);
    checkOutput("edgeDrained", expQ.size(), 0);
    checkOutput("edgeCrash", 32'(crash), 32'b1000);
    checkOutput("edgeIdle", 32'(busy), 0);

    $display("[TB] clear during CHK, then clear restart");
    c = cyc;
    applyStimulus(0, 5, 101);
    expectRead(cellOf(5, 101), c + 2);
    stepTo(c + 3);
    clear_req = 1'b1;
    d = c + 104;
    for (int j = 0; j <= 100; j++) expectWrite(j, 0, c + 4 + j);
    for (int j = 0; j < 19200; j++) expectWrite(j, 0, d + 1 + j);
    step(1);
    clear_req    = 1'b0;
    masterSwitch = 1'b0;
    checkOutput("abortCrashCleared", 32'(crash), 0);
    checkOutput("abortBusy", 32'(busy), 1);
    stepTo(d);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    stepTo(d + 19200);
    checkOutput("restartBusyLast", 32'(busy), 1);
    step(1);
    checkOutput("restartBusyFall", 32'(busy), 0);
    checkOutput("restartDrained", expQ.size(), 0);
    step(10);
    checkOutput("switchOffQuiet", 32'(busy), 0);
    checkOutput("finalCrash", 32'(crash), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
